// File: rtl/bsg_up_link_send_ctrl.sv
// Credit-gated send controller for the upstream link.
// Serialises each accepted core word into BEATS back-to-back beats across
// CH_NUM byte-wide channels. Each accepted word consumes one downstream credit,
// and each io_token_i pulse returns one.
module bsg_up_link_send_ctrl #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CH_NUM     = 2,
  parameter int unsigned CH_WIDTH   = 8,
  parameter int unsigned CREDIT_MAX = 64,
  parameter int unsigned CNT_WIDTH  = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        core_data_i,
  input  logic                         core_valid_i,
  output logic                         core_ready_o,
  input  logic                         io_token_i,
  output logic                         io_valid_o,
  output logic [CH_NUM*CH_WIDTH-1:0]   io_data_o,
  output logic [CNT_WIDTH-1:0]         credits_avail_o,
  output logic                         busy_o,
  output logic                         token_err_o
);

  localparam int unsigned IO_W   = CH_NUM * CH_WIDTH;
  localparam int unsigned BEATS  = DATA_WIDTH / IO_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0]    LAST_BEAT    = BEAT_W'(BEATS - 1);
  localparam logic [CNT_WIDTH-1:0] CREDIT_MAX_C = CNT_WIDTH'(CREDIT_MAX);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  sent_cnt_q, sent_cnt_d;
  logic [CNT_WIDTH-1:0]  finish_cnt_q, finish_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  io_valid_q, io_valid_d;
  logic [IO_W-1:0]       io_data_q, io_data_d;
  logic                  busy_q, busy_d;
  logic                  token_err_q, token_err_d;

  logic [CNT_WIDTH-1:0]  outstanding;
  logic                  accept;

  // Words in flight; modular subtract keeps this correct across counter wrap.
  assign outstanding     = sent_cnt_q - finish_cnt_q;
  assign credits_avail_o = CREDIT_MAX_C - outstanding;

  // Ready is a function of registered state only.
  assign core_ready_o = ((state_q == IDLE) || ((state_q == SEND) && (beat_q == LAST_BEAT)))
                        && (outstanding < CREDIT_MAX_C);
  assign accept       = core_valid_i && core_ready_o;

  assign io_valid_o  = io_valid_q;
  assign io_data_o   = io_data_q;
  assign busy_o      = busy_q;
  assign token_err_o = token_err_q;

  // Next-state: beat sequencing, credit counters and registered beat output.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    sent_cnt_d   = sent_cnt_q;
    finish_cnt_d = finish_cnt_q;
    data_d       = data_q;
    token_err_d  = token_err_q;
    io_valid_d   = 1'b0;
    io_data_d    = '0;
    busy_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          beat_d  = '0;
        end
      end
      SEND: begin
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = accept ? SEND : IDLE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase

    if (accept) begin
      data_d     = core_data_i;
      sent_cnt_d = sent_cnt_q + CNT_WIDTH'(1);
    end

    if (io_token_i) begin
      if (outstanding != '0) begin
        finish_cnt_d = finish_cnt_q + CNT_WIDTH'(1);
      end else begin
        token_err_d = 1'b1;
      end
    end

    io_valid_d = (state_d == SEND);
    busy_d     = (state_d == SEND);
    if (state_d == SEND) begin
      for (int unsigned b = 0; b < BEATS; b++) begin
        if (beat_d == BEAT_W'(b)) begin
          io_data_d = data_d[b*IO_W +: IO_W];
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      sent_cnt_q   <= '0;
      finish_cnt_q <= '0;
      data_q       <= '0;
      io_valid_q   <= 1'b0;
      io_data_q    <= '0;
      busy_q       <= 1'b0;
      token_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      sent_cnt_q   <= sent_cnt_d;
      finish_cnt_q <= finish_cnt_d;
      data_q       <= data_d;
      io_valid_q   <= io_valid_d;
      io_data_q    <= io_data_d;
      busy_q       <= busy_d;
      token_err_q  <= token_err_d;
    end
  end

  // Structural invariants.
  a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
    outstanding <= CREDIT_MAX_C);
  a_valid_implies_busy: assert property (@(posedge clk) disable iff (rst)
    io_valid_o |-> busy_o);
  a_beat_range: assert property (@(posedge clk) disable iff (rst)
    32'(beat_q) < BEATS);

endmodule
